// File: rtl/fpu_pkg.sv
// Shared floating-point definitions: rounding-mode codes, flag bit order,
// and helpers producing the all-ones exponent and largest finite magnitude.
package fpu_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RDN = 3'b001;
    localparam logic [2:0] RM_RUP = 3'b010;
    localparam logic [2:0] RM_RTZ = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // flags = {nv, dz, of, uf, nx}
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;
    localparam int FLAG_W  = 5;

    // Wide enough to hold any supported exponent+fraction encoding.
    localparam int ENC_W = 128;

    // Reserved rounding codes behave as round-to-nearest-even.
    function automatic logic [2:0] fp_rm_canon(input logic [2:0] rm_v);
        if (rm_v > RM_RMM) begin
            return RM_RNE;
        end else begin
            return rm_v;
        end
    endfunction

    // All-ones exponent field, right-aligned.
    function automatic logic [ENC_W-1:0] fp_exp_all_ones(input int exp_w);
        logic [ENC_W-1:0] one_v;
        one_v = 128'd1;
        return (one_v << exp_w) - one_v;
    endfunction

    // Largest finite magnitude {all-ones-minus-one exponent, all-ones fraction}.
    function automatic logic [ENC_W-1:0] fp_max_finite(input int exp_w, input int frac_w);
        logic [ENC_W-1:0] one_v;
        one_v = 128'd1;
        return ((one_v << (exp_w + frac_w)) - one_v) - (one_v << frac_w);
    endfunction

endpackage

// File: rtl/fp_lzc_shift.sv
// Leading-zero count with a logarithmic left shifter: each stage checks the
// top 2^k bits and shifts them out when they are all zero.
module fp_lzc_shift #(
    parameter  int W  = 27,
    localparam int ZW = $clog2(W + 1)
) (
    input  logic [W-1:0]  data,
    output logic [ZW-1:0] zcnt,
    output logic [W-1:0]  shifted
);

    logic [W-1:0]  cur_s;
    logic [ZW-1:0] cnt_s;

    // Walk the power-of-two stages from the widest down to a single bit.
    always_comb begin
        cur_s = data;
        cnt_s = '0;
        for (int k = ZW - 1; k >= 0; k--) begin
            if ((cur_s >> (W - (1 << k))) == '0) begin
                cur_s = cur_s << (1 << k);
                cnt_s = cnt_s | ZW'(1 << k);
            end else begin
                cur_s = cur_s;
                cnt_s = cnt_s;
            end
        end
    end

    assign zcnt    = cnt_s;
    assign shifted = cur_s;

endmodule

// File: rtl/fadd_norm_pipe.sv
// Two-stage normalise / round-and-pack back end of the floating-point adder
// with a valid/ready handshake and a synchronous flush.
module fadd_norm_pipe
    import fpu_pkg::*;
#(
    parameter  int EXP_W  = 8,
    parameter  int FRAC_W = 23,
    localparam int CF_W   = FRAC_W + 5
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              rm,
    input  logic                    sign,
    input  logic                    is_nan,
    input  logic                    is_inf,
    input  logic [FRAC_W-1:0]       inf_nan_frac,
    input  logic [EXP_W-1:0]        temp_exp,
    input  logic [CF_W-1:0]         cal_frac,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   s,
    output logic [FLAG_W-1:0]       flags
);

    localparam int F0_W  = CF_W - 1;
    localparam int ZW    = $clog2(F0_W + 1);
    localparam int CMP_W = (EXP_W > ZW) ? EXP_W : ZW;
    localparam logic [ENC_W-1:0] EXP_ONES_V = fp_exp_all_ones(EXP_W);
    localparam logic [ENC_W-1:0] MAX_FIN_V  = fp_max_finite(EXP_W, FRAC_W);
    localparam logic [EXP_W-1:0] EXP_ONES   = EXP_ONES_V[EXP_W-1:0];
    localparam logic [EXP_W+FRAC_W-1:0] MAX_FIN = MAX_FIN_V[EXP_W+FRAC_W-1:0];
    localparam logic [EXP_W-1:0] EXP_ONE    = {{(EXP_W-1){1'b0}}, 1'b1};

    // ---------------- stage 1: normalise ----------------
    logic [F0_W-1:0]   low_s;
    logic [ZW-1:0]     zcnt_s;
    logic [F0_W-1:0]   norm_s;
    logic [CMP_W-1:0]  texp_ext_s;
    logic [CMP_W-1:0]  z_ext_s;
    logic [F0_W-1:0]   f0_nx_s;
    logic [EXP_W-1:0]  e0_nx_s;

    logic              s1_valid_r;
    logic [F0_W-1:0]   f0_r;
    logic [EXP_W-1:0]  e0_r;
    logic [2:0]        rm_r;
    logic              sign_r;
    logic              nan_r;
    logic              inf_r;
    logic [FRAC_W-1:0] pl_r;

    logic              s2_ready_s;

    assign low_s      = cal_frac[F0_W-1:0];
    assign texp_ext_s = CMP_W'(temp_exp);
    assign z_ext_s    = CMP_W'(zcnt_s);

    fp_lzc_shift #(.W(F0_W)) u_lzc (
        .data    (low_s),
        .zcnt    (zcnt_s),
        .shifted (norm_s)
    );

    // Choose carry right-shift, full normalisation, or denormal alignment.
    always_comb begin
        f0_nx_s = '0;
        e0_nx_s = '0;
        if (cal_frac[CF_W-1]) begin
            f0_nx_s = {cal_frac[CF_W-1:2], cal_frac[1] | cal_frac[0]};
            e0_nx_s = temp_exp + EXP_ONE;
        end else if ((texp_ext_s > z_ext_s) && norm_s[F0_W-1]) begin
            f0_nx_s = norm_s;
            e0_nx_s = temp_exp - EXP_W'(zcnt_s);
        end else if (temp_exp != '0) begin
            f0_nx_s = low_s << (temp_exp - EXP_ONE);
            e0_nx_s = '0;
        end else begin
            f0_nx_s = low_s;
            e0_nx_s = '0;
        end
    end

    assign s2_ready_s = ~out_valid | out_ready;
    assign in_ready   = ~s1_valid_r | s2_ready_s;

    // Stage-1 register: flush wins over a load; payload captured on transfer.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1_valid_r <= 1'b0;
            f0_r       <= '0;
            e0_r       <= '0;
            rm_r       <= RM_RNE;
            sign_r     <= 1'b0;
            nan_r      <= 1'b0;
            inf_r      <= 1'b0;
            pl_r       <= '0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                f0_r   <= f0_nx_s;
                e0_r   <= e0_nx_s;
                rm_r   <= fp_rm_canon(rm);
                sign_r <= sign;
                nan_r  <= is_nan;
                inf_r  <= is_inf;
                pl_r   <= inf_nan_frac;
            end
        end
    end

    // ---------------- stage 2: round and pack ----------------
    logic                  any_s;
    logic                  inc_s;
    logic                  to_inf_s;
    logic [FRAC_W+1:0]     fr_s;
    logic [EXP_W-1:0]      exp_rnd_s;
    logic [EXP_W-1:0]      exp_s;
    logic                  of_s;
    logic                  nx_s;
    logic [EXP_W+FRAC_W:0] res_s;
    logic [FLAG_W-1:0]     flags_s;

    logic [EXP_W+FRAC_W:0] s_r;
    logic [FLAG_W-1:0]     flags_r;
    logic                  out_valid_r;

    assign any_s = f0_r[2] | f0_r[1] | f0_r[0];

    // Round-increment decision and overflow saturation direction per mode.
    always_comb begin
        inc_s    = 1'b0;
        to_inf_s = 1'b1;
        case (rm_r)
            RM_RNE: begin
                inc_s    = f0_r[2] & (f0_r[1] | f0_r[0] | f0_r[3]);
                to_inf_s = 1'b1;
            end
            RM_RMM: begin
                inc_s    = f0_r[2];
                to_inf_s = 1'b1;
            end
            RM_RDN: begin
                inc_s    = sign_r & any_s;
                to_inf_s = sign_r;
            end
            RM_RUP: begin
                inc_s    = ~sign_r & any_s;
                to_inf_s = ~sign_r;
            end
            RM_RTZ: begin
                inc_s    = 1'b0;
                to_inf_s = 1'b0;
            end
            default: begin
                inc_s    = f0_r[2] & (f0_r[1] | f0_r[0] | f0_r[3]);
                to_inf_s = 1'b1;
            end
        endcase
    end

    assign fr_s      = {1'b0, f0_r[CF_W-2:3]} + {{(FRAC_W+1){1'b0}}, inc_s};
    assign exp_rnd_s = e0_r + {{(EXP_W-1){1'b0}}, fr_s[FRAC_W+1]};

    // Final exponent, special-case priority and exception flags.
    always_comb begin
        exp_s   = exp_rnd_s;
        res_s   = '0;
        flags_s = '0;
        if ((e0_r == '0) && fr_s[FRAC_W]) begin
            exp_s = EXP_ONE;
        end else begin
            exp_s = exp_rnd_s;
        end
        of_s = ((e0_r == EXP_ONES) | (exp_s == EXP_ONES)) & ~nan_r & ~inf_r;
        nx_s = (any_s | of_s) & ~nan_r & ~inf_r;
        if (nan_r) begin
            res_s = {1'b1, EXP_ONES, pl_r};
        end else if (inf_r) begin
            res_s = {sign_r, EXP_ONES, pl_r};
        end else if (of_s) begin
            if (to_inf_s) begin
                res_s = {sign_r, EXP_ONES, {FRAC_W{1'b0}}};
            end else begin
                res_s = {sign_r, MAX_FIN};
            end
        end else begin
            res_s = {sign_r, exp_s, fr_s[FRAC_W-1:0]};
        end
        flags_s[FLAG_NV] = nan_r;
        flags_s[FLAG_DZ] = 1'b0;
        flags_s[FLAG_OF] = of_s;
        flags_s[FLAG_UF] = (e0_r == '0) & nx_s;
        flags_s[FLAG_NX] = nx_s;
    end

    // Output register: holds result while stalled, flush drops it.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            out_valid_r <= 1'b0;
            s_r         <= '0;
            flags_r     <= '0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (s2_ready_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s_r     <= res_s;
                flags_r <= flags_s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign s         = s_r;
    assign flags     = flags_r;

endmodule
